regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32x32 two-read/one-write register file among NUM_REQ requesters, e.g. ALU writeback, load unit and debug/host port.
- Round-robin arbitration with an optional bounded burst lock, so one requester can perform back-to-back writes.
- Write outputs are registered and drive the register file write address/data/enable inputs directly.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_write_arbiter_if.sv | 25 ++
 rtl/rr_pick.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and write-arbiter state encoding.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int REG_COUNT  = 32;

   typedef enum logic {
      ARB_S  = 1'b0,
      LOCK_S = 1'b1
   } arbState_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side bundle of the register-file write arbiter.
interface regfile_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_lock;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      hold;

   modport master (
      output req_valid, req_lock, req_addr, req_data, hold,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_lock, req_addr, req_data, hold,
      output req_ready
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin first-set finder starting at ptr.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          anyGrant
);

   int j;

   always_comb begin
      grant    = '0;
      idx      = '0;
      anyGrant = 1'b0;
      j        = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!anyGrant && req[j]) begin
            grant[j] = 1'b1;
            idx      = IW'(j);
            anyGrant = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter with bounded burst lock.
// Option: REGFILE_ARB_ZERO_DISCARD_EN drops writes to register 0.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int DATA_W   = REG_DATA_W,
   parameter int MAX_LOCK = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   regfile_write_arbiter_if.slave     req,
   output logic                       rf_we,
   output logic [ADDR_W-1:0]          rf_wr_addr,
   output logic [DATA_W-1:0]          rf_wr_data,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       locked
);

   localparam int IW = $clog2(NUM_REQ);

   arbState_e          state, stateNext;
   logic [IW-1:0]      rrPtr, rrPtrNext;
   logic [IW-1:0]      owner, ownerNext;
   logic [7:0]         lockCnt, lockCntNext;
   logic [NUM_REQ-1:0] pickReq, pickGrant, ready;
   logic [IW-1:0]      pickIdx, grantIdx;
   logic               pickAny, xfer, issue;
   logic [ADDR_W-1:0]  wrAddr;
   logic [DATA_W-1:0]  wrData;

   function automatic logic [IW-1:0] wrapInc(logic [IW-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + IW'(1);
   endfunction

   assign pickReq = (rst || req.hold || state == LOCK_S) ? '0 : req.req_valid;

   rr_pick #(.N(NUM_REQ), .IW(IW)) uPick (
      .req      (pickReq),
      .ptr      (rrPtr),
      .grant    (pickGrant),
      .idx      (pickIdx),
      .anyGrant (pickAny)
   );

   always_comb begin
      stateNext   = state;
      rrPtrNext   = rrPtr;
      ownerNext   = owner;
      lockCntNext = lockCnt;
      ready       = '0;
      grantIdx    = pickIdx;
      xfer        = 1'b0;
      unique case (state)
         ARB_S: begin
            if (pickAny) begin
               ready     = pickGrant;
               xfer      = 1'b1;
               rrPtrNext = wrapInc(pickIdx);
               if (req.req_lock[pickIdx] && MAX_LOCK > 1) begin
                  stateNext   = LOCK_S;
                  ownerNext   = pickIdx;
                  lockCntNext = 8'd1;
               end
            end
         end
         LOCK_S: begin
            // hold freezes the burst; an idle owner releases it
            if (!rst && !req.hold) begin
               if (req.req_valid[owner]) begin
                  ready[owner] = 1'b1;
                  xfer         = 1'b1;
                  grantIdx     = owner;
                  lockCntNext  = lockCnt + 8'd1;
                  if (!req.req_lock[owner] ||
                      lockCnt + 8'd1 == 8'(MAX_LOCK)) begin
                     stateNext   = ARB_S;
                     rrPtrNext   = wrapInc(owner);
                     lockCntNext = 8'd0;
                  end
               end else begin
                  stateNext   = ARB_S;
                  lockCntNext = 8'd0;
               end
            end
         end
         default: ;
      endcase
   end

   assign req.req_ready = ready;
   assign wrAddr = req.req_addr[grantIdx*ADDR_W +: ADDR_W];
   assign wrData = req.req_data[grantIdx*DATA_W +: DATA_W];

`ifdef REGFILE_ARB_ZERO_DISCARD_EN
   assign issue = xfer && (wrAddr != '0);
`else
   assign issue = xfer;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ARB_S;
         rrPtr   <= '0;
         owner   <= '0;
         lockCnt <= 8'd0;
      end else begin
         state   <= stateNext;
         rrPtr   <= rrPtrNext;
         owner   <= ownerNext;
         lockCnt <= lockCntNext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we      <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
         grant_id   <= '0;
      end else begin
         rf_we <= issue;
         if (issue) begin
            rf_wr_addr <= wrAddr;
            rf_wr_data <= wrData;
            grant_id   <= grantIdx;
         end
      end
   end

   assign locked = (state == LOCK_S);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus randomized bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

   localparam int N  = 4;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int ML = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          rf_we;
   logic [AW-1:0] rf_wr_addr;
   logic [DW-1:0] rf_wr_data;
   logic [1:0]    grant_id;
   logic          locked;

   int checks = 0;
   int errors = 0;

   int          mPtr, mOwner, mCnt;
   bit          mLocked;
   logic        expWe;
   logic [31:0] expAddr, expData, expGid;

`ifdef REGFILE_ARB_ZERO_DISCARD_EN
   localparam bit ZD = 1'b1;
`else
   localparam bit ZD = 1'b0;
`endif

   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) busIf ();

   regfile_write_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (busIf),
      .rf_we      (rf_we),
      .rf_wr_addr (rf_wr_addr),
      .rf_wr_data (rf_wr_data),
      .grant_id   (grant_id),
      .locked     (locked)
   );

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Who the spec says gets the write port this cycle (-1 = nobody).
   function automatic int modelPick();
      if (rst || busIf.hold) return -1;
      if (mLocked) return busIf.req_valid[mOwner] ? mOwner : -1;
      for (int k = 0; k < N; k++)
         if (busIf.req_valid[(mPtr + k) % N]) return (mPtr + k) % N;
      return -1;
   endfunction

   task automatic setReq(int i, bit v, bit l, logic [4:0] a, logic [31:0] d);
      busIf.req_valid[i]         = v;
      busIf.req_lock[i]          = l;
      busIf.req_addr[i*AW +: AW] = a;
      busIf.req_data[i*DW +: DW] = d;
   endtask

   task automatic stepCycle();
      int          g;
      logic [3:0]  expReady;
      logic [31:0] a, d;
      bit          l;
      #1;
      g = modelPick();
      expReady = (g >= 0) ? 4'(1 << g) : 4'd0;
      check("ready", 32'(busIf.req_ready), 32'(expReady));
      a = (g >= 0) ? 32'(busIf.req_addr[g*AW +: AW]) : 32'd0;
      d = (g >= 0) ? busIf.req_data[g*DW +: DW] : 32'd0;
      l = (g >= 0) ? busIf.req_lock[g] : 1'b0;
      @(posedge clk);
      if (rst) begin
         mPtr = 0; mOwner = 0; mCnt = 0; mLocked = 0;
         expWe = 0; expAddr = 0; expData = 0; expGid = 0;
      end else if (g >= 0) begin
         if (ZD && a == 0) expWe = 0;
         else begin
            expWe = 1; expAddr = a; expData = d; expGid = 32'(g);
         end
         if (mLocked) begin
            mCnt++;
            if (!l || mCnt == ML) begin
               mLocked = 0; mCnt = 0; mPtr = (g + 1) % N;
            end
         end else begin
            mPtr = (g + 1) % N;
            if (l && ML > 1) begin
               mLocked = 1; mOwner = g; mCnt = 1;
            end
         end
      end else begin
         expWe = 0;
         if (mLocked && !busIf.hold) begin
            mLocked = 0; mCnt = 0;
         end
      end
      #1;
      check("rf_we", 32'(rf_we), 32'(expWe));
      check("rf_wr_addr", 32'(rf_wr_addr), expAddr);
      check("rf_wr_data", rf_wr_data, expData);
      check("grant_id", 32'(grant_id), expGid);
      check("locked", 32'(locked), 32'(mLocked));
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      busIf.req_valid = '0;
      busIf.req_lock  = '0;
      busIf.req_addr  = '0;
      busIf.req_data  = '0;
      busIf.hold      = 1'b0;
      mPtr = 0; mOwner = 0; mCnt = 0; mLocked = 0;
      expWe = 0; expAddr = 0; expData = 0; expGid = 0;
      @(negedge clk);
      stepCycle();
      stepCycle();
      rst = 1'b0;

      // single write from requester 0
      setReq(0, 1, 0, 5'd4, 32'd7);
      stepCycle();
      check("first_addr", 32'(rf_wr_addr), 32'd4);
      check("first_data", rf_wr_data, 32'd7);

      // all valid, no lock: plain rotation
      for (int i = 0; i < N; i++) setReq(i, 1, 0, 5'(i + 8), 32'(100 + i));
      for (int c = 0; c < 8; c++) begin
         stepCycle();
         check("rr_order", 32'(grant_id), 32'((c + 1) % N));
      end

      // requester 1 bursts to MAX_LOCK
      busIf.req_lock[1] = 1'b1;
      for (int c = 0; c < 14; c++) stepCycle();
      busIf.req_lock[1] = 1'b0;

      // hold with everyone valid
      busIf.hold = 1'b1;
      for (int c = 0; c < 3; c++) stepCycle();
      busIf.hold = 1'b0;
      for (int c = 0; c < 3; c++) stepCycle();

      // reset collides with a transfer
      busIf.req_valid = '0;
      setReq(2, 1, 0, 5'd5, 32'd13);
      rst = 1'b1;
      stepCycle();
      check("rst_xfer_we", 32'(rf_we), 32'd0);
      rst = 1'b0;
      busIf.req_valid = '0;
      stepCycle();

      // address-0 write
      setReq(0, 1, 0, 5'd0, 32'hFF);
      stepCycle();
      busIf.req_valid = '0;
      stepCycle();

      // randomized traffic
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < N; i++)
            setReq(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                   5'($urandom_range(0, 31)), $urandom);
         busIf.hold = ($urandom_range(0, 7) == 0);
         rst = ($urandom_range(0, 59) == 0);
         stepCycle();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
